// File: rtl/buffer_arbiter.sv
// buffer_arbiter: round-robin NUM_REQ:1 arbiter with a one-word hold buffer on the output.
// Defining BUFFER_ARBITER_STATS_EN adds a saturating output-transfer counter (xfer_count_o).
//
// state   | meaning
// S_EMPTY | hold register unused; granted request passes straight through
// S_HOLD  | hold register carries one accepted word awaiting out_ready_i
module buffer_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     out_valid_o,
  output logic [WIDTH-1:0]         out_data_o,
  input  logic                     out_ready_i,
  output logic [GW-1:0]            out_grant_o
`ifdef BUFFER_ARBITER_STATS_EN
  ,
  output logic [15:0]              xfer_count_o
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    hold_idx_q, hold_idx_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [GW-1:0]    grant, grant_hi, grant_lo, grant_nxt;
  logic             found_hi;
  logic             any_req;
  logic [WIDTH-1:0] grant_data;

  assign any_req = |req_valid_i;

  // Downward scan: the last hit is the lowest valid index at/above ptr, else the lowest overall.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        if (k >= int'(ptr_q)) begin
          grant_hi = GW'(k);
          found_hi = 1'b1;
        end else begin
          grant_lo = GW'(k);
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  assign grant_nxt  = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  assign grant_data = req_data_i[int'(grant)*WIDTH +: WIDTH];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_data_d = hold_data_q;
    hold_idx_d  = hold_idx_q;
    req_ready_o = '0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_grant_o = '0;
    case (state_q)
      S_EMPTY: begin
        if (any_req) begin
          out_valid_o = 1'b1;
          out_data_o  = grant_data;
          out_grant_o = grant;
          req_ready_o = NUM_REQ'(1) << grant;
          ptr_d       = grant_nxt;
          if (!out_ready_i) begin
            state_d     = S_HOLD;
            hold_data_d = grant_data;
            hold_idx_d  = grant;
          end
        end
      end
      S_HOLD: begin
        out_valid_o = 1'b1;
        out_data_o  = hold_data_q;
        out_grant_o = hold_idx_q;
        if (out_ready_i) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q     <= S_EMPTY;
      ptr_q       <= '0;
      hold_data_q <= '0;
      hold_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_data_q <= hold_data_d;
      hold_idx_q  <= hold_idx_d;
    end
  end

`ifdef BUFFER_ARBITER_STATS_EN
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      xfer_count_o <= '0;
    end else if (out_valid_o && out_ready_i && (xfer_count_o != 16'hFFFF)) begin
      xfer_count_o <= xfer_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_buffer_arbiter.sv
// tb_buffer_arbiter: directed vector table plus hand sequences for hold, wrap and reset corners.
// Define BUFFER_ARBITER_STATS_EN to also exercise the saturating transfer counter.
module tb_buffer_arbiter;

  localparam logic [31:0] D0 = 32'h44332211;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_ready_i;
  logic [1:0]  out_grant_o;
`ifdef BUFFER_ARBITER_STATS_EN
  logic [15:0] xfer_count_o;
`endif

  int total  = 0;
  int passed = 0;

  always #10 clk_i = ~clk_i;

  buffer_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .out_grant_o (out_grant_o)
`ifdef BUFFER_ARBITER_STATS_EN
    ,
    .xfer_count_o(xfer_count_o)
`endif
  );

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] data;
    logic        ord;
    logic [3:0]  ready;
    logic        valid;
    logic [7:0]  dout;
    logic [1:0]  grant;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_out(input string tag, input logic [3:0] er, input logic ev,
                           input logic [7:0] ed, input logic [1:0] eg);
    check({tag, " ready"}, {28'd0, req_ready_o}, {28'd0, er});
    check({tag, " valid"}, {31'd0, out_valid_o}, {31'd0, ev});
    check({tag, " data"},  {24'd0, out_data_o},  {24'd0, ed});
    check({tag, " grant"}, {30'd0, out_grant_o}, {30'd0, eg});
  endtask

  task automatic step(input string tag, input logic [3:0] rv, input logic [31:0] d,
                      input logic ord, input logic [3:0] er, input logic ev,
                      input logic [7:0] ed, input logic [1:0] eg);
    @(negedge clk_i);
    req_valid_i = rv;
    req_data_i  = d;
    out_ready_i = ord;
    #2;
    check_out(tag, er, ev, ed, eg);
  endtask

  initial begin
    // round-robin over all four, then idle, sparse patterns and wrap from ptr=3
    vecs[0]  = '{4'b1111, D0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[1]  = '{4'b1111, D0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    vecs[2]  = '{4'b1111, D0, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    vecs[3]  = '{4'b1111, D0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    vecs[4]  = '{4'b1111, D0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[5]  = '{4'b0000, D0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[6]  = '{4'b0001, D0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[7]  = '{4'b1010, D0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    vecs[8]  = '{4'b1010, D0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    vecs[9]  = '{4'b0100, D0, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    vecs[10] = '{4'b1001, D0, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    vecs[11] = '{4'b1001, D0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};

    rst_ni      = 1'b1;
    req_valid_i = 4'b0000;
    req_data_i  = D0;
    out_ready_i = 1'b0;
    #3;
    check_out("reset idle", 4'b0000, 1'b0, 8'h00, 2'd0);
    req_valid_i = 4'b0100;
    #2;
    check_out("reset comb", 4'b0100, 1'b1, 8'h33, 2'd2);
    req_valid_i = 4'b0000;
    @(negedge clk_i);
    rst_ni = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rv, vecs[i].data, vecs[i].ord,
           vecs[i].ready, vecs[i].valid, vecs[i].dout, vecs[i].grant);
    end

    // ptr=1: requester 2 held for three stalled cycles, dropping its request meanwhile
    step("hold c0", 4'b0100, 32'h00A50000, 1'b0, 4'b0100, 1'b1, 8'hA5, 2'd2);
    step("hold c1", 4'b0000, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2);
    step("hold c2", 4'b0100, 32'h00110000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2);
    step("hold c3", 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd2);
    step("hold c4", 4'b0000, D0,           1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);

    // ptr=3: hold word from requester 0, release it while requester 1 waits
    step("drain c0", 4'b0001, 32'h4433225A, 1'b0, 4'b0001, 1'b1, 8'h5A, 2'd0);
    step("drain c1", 4'b0010, D0,           1'b1, 4'b0000, 1'b1, 8'h5A, 2'd0);
    step("drain c2", 4'b0010, D0,           1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);

    // ptr=2: hold 3C then reset asynchronously mid-cycle
    step("rsth c0", 4'b0001, 32'h4433223C, 1'b0, 4'b0001, 1'b1, 8'h3C, 2'd0);
    @(negedge clk_i);
    req_valid_i = 4'b0000;
    req_data_i  = D0;
    out_ready_i = 1'b0;
    #2;
    check_out("rsth held", 4'b0000, 1'b1, 8'h3C, 2'd0);
    #1 rst_ni = 1'b1;
    #1;
    check_out("rsth async", 4'b0000, 1'b0, 8'h00, 2'd0);
    req_valid_i = 4'b0100;
    #1;
    check_out("rsth comb", 4'b0100, 1'b1, 8'h33, 2'd2);
    req_valid_i = 4'b0000;
    @(negedge clk_i);
    rst_ni = 1'b0;
    step("rsth ptr0", 4'b1111, D0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    step("rsth ptr1", 4'b1111, D0, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);

`ifdef BUFFER_ARBITER_STATS_EN
    @(negedge clk_i);
    req_valid_i = 4'b0000;
    rst_ni = 1'b1;
    #2;
    check("count reset", {16'd0, xfer_count_o}, 32'd0);
    @(negedge clk_i);
    rst_ni      = 1'b0;
    req_valid_i = 4'b1111;
    out_ready_i = 1'b1;
    for (int i = 0; i < 70000; i++) @(posedge clk_i);
    @(negedge clk_i);
    check("count sat", {16'd0, xfer_count_o}, 32'h0000FFFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/buffer_arbiter.md
BUFFER_ARBITER -- requirements
Module: buffer_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 4, as the number of requesters sharing the output path (legal range 2..16).
REQ-002 The block SHALL take parameter WIDTH, default 8, as the data width per requester.
REQ-003 The block SHALL have clk_i, input, 1 bit, as the single clock; all state is on its rising edge.
REQ-004 The block SHALL have rst_ni, input, 1 bit, as the reset: asynchronous, active-high (1 = reset asserted).
REQ-005 The block SHALL have req_valid_i, input, NUM_REQ bits: bit k means requester k presents data.
REQ-006 The block SHALL have req_data_i, input, NUM_REQ*WIDTH bits: requester k's data in slice [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have req_ready_o, output, NUM_REQ bits: bit k means requester k's data is accepted this cycle.
REQ-008 The block SHALL have out_valid_o, output, 1 bit: output data is valid.
REQ-009 The block SHALL have out_data_o, output, WIDTH bits: output data.
REQ-010 The block SHALL have out_ready_i, input, 1 bit: the downstream consumes the data this cycle.
REQ-011 The block SHALL have out_grant_o, output, max(1,$clog2(NUM_REQ)) bits: index of the requester whose data is on out_data_o.

Function
REQ-012 The block SHALL hold a state machine with two states: EMPTY (hold register unused) and HOLD (hold register carries one accepted word).
REQ-013 The block SHALL keep a round-robin pointer ptr; grant = first k with req_valid_i[k]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
REQ-014 In EMPTY, the block SHALL set out_valid_o = |req_valid_i, drive out_data_o and out_grant_o from the granted requester combinationally (zero latency), and set req_ready_o = one-hot(grant) whenever any request is valid.
REQ-015 In EMPTY with a valid request and out_ready_i=1, the block SHALL complete the transfer and stay in EMPTY.
REQ-016 In EMPTY with a valid request and out_ready_i=0, the block SHALL capture the granted data and index into the hold register and go to HOLD.
REQ-017 In HOLD, the block SHALL drive out_valid_o=1, out_data_o and out_grant_o from the hold register, and req_ready_o=0.
REQ-018 In HOLD with out_ready_i=1, the block SHALL return to EMPTY next cycle and accept no new request that cycle.
REQ-019 On every acceptance (req_ready_o nonzero), the block SHALL set ptr <= (grant+1) mod NUM_REQ; otherwise ptr SHALL hold.
REQ-020 Once out_valid_o rises, out_data_o and out_grant_o SHALL stay stable until the cycle out_ready_i=1.
REQ-021 With req_valid_i=0 in EMPTY, the block SHALL drive out_valid_o=0, req_ready_o=0, out_data_o=0 and out_grant_o=0.
REQ-022 A requester deasserting req_valid_i in the same cycle it is granted but not accepted SHALL have no effect, because acceptance happens in that cycle.

Reset
REQ-023 While rst_ni=1, the block SHALL clear asynchronously: state=EMPTY, ptr=0, hold data=0, hold index=0.
REQ-024 A reset in HOLD SHALL discard the held word; outputs then follow REQ-021 or REQ-014 combinationally from the current inputs.

Configuration
REQ-025 With macro BUFFER_ARBITER_STATS_EN defined, the block SHALL add output xfer_count_o, 16 bits: a count of completed output transfers (out_valid_o & out_ready_i), saturating at 16'hFFFF and cleared by reset.
REQ-026 Without BUFFER_ARBITER_STATS_EN, the block SHALL not have port xfer_count_o and SHALL not contain the counter logic.

Verification
REQ-027 Bench: reset, NUM_REQ=4, req_valid_i=4'b1111, out_ready_i=1 held -> grants 0,1,2,3,0 on consecutive cycles, data passed through the same cycle.
REQ-028 Bench: req_valid_i=4'b0100, data2=8'hA5, out_ready_i=0 for 3 cycles then 1 -> req_ready_o=4'b0100 only in cycle 0; out_data_o=8'hA5 and out_grant_o=2 stable for 4 cycles; EMPTY after.
REQ-029 Bench: ptr=3, req_valid_i=4'b1001 -> grant 3, then ptr=0 -> grant 0 (wrap-around).
REQ-030 Bench: assert rst_ni in HOLD holding 8'h3C -> out_valid_o falls asynchronously when req_valid_i=0; ptr=0 after release.
REQ-031 Bench: in HOLD with out_ready_i=1 and req_valid_i=4'b0010 -> req_ready_o=0 that cycle; requester 1 accepted the next cycle.
REQ-032 Bench with BUFFER_ARBITER_STATS_EN: 70000 back-to-back transfers -> xfer_count_o=16'hFFFF, no wrap.
